// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encodings, frame geometry
// and line levels.
package uart_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] START     = 3'd1;
  localparam logic [STATE_W-1:0] DATA      = 3'd2;
  localparam logic [STATE_W-1:0] STOP      = 3'd3;
  localparam logic [STATE_W-1:0] WAIT_HIGH = 3'd4;

  localparam int unsigned DATA_BITS = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  // The receiver is busy in every state except IDLE.
  function automatic logic state_busy(input logic [STATE_W-1:0] s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to the idle line level
// so a reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= {WIDTH{LINE_IDLE}};
      q    <= {WIDTH{LINE_IDLE}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit start qualification, centre sampling of data and
// stop bits, one-cycle valid / frame-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] d_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned H       = CLKS_PER_BIT / 2;
  localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IDX_W   = $clog2(DATA_BITS);

  logic                 rx_s;
  logic [STATE_W-1:0]   state, state_d;
  logic [TIMER_W-1:0]   timer, timer_d;
  logic [IDX_W-1:0]     bit_idx, bit_idx_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [7:0]           d_d;
  logic                 valid_d, ferr_d, busy_d;
  logic                 timer_done;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_i),
    .q     (rx_s)
  );

  // Sampling point is reached when the timer has counted down to one.
  assign timer_done = (timer == TIMER_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      d_o         <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      bit_idx     <= bit_idx_d;
      shift       <= shift_d;
      d_o         <= d_d;
      valid_o     <= valid_d;
      frame_err_o <= ferr_d;
      busy_o      <= busy_d;
    end
  end

  // Next-state, timer, shift register and registered-output next values.
  always_comb begin
    state_d   = state;
    timer_d   = timer;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    d_d       = d_o;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state)
      IDLE: begin
        if (rx_s == START_LVL) begin
          timer_d = TIMER_W'(H);
          state_d = START;
        end
      end

      START: begin
        if (timer_done) begin
          if (rx_s == START_LVL) begin
            timer_d   = TIMER_W'(CLKS_PER_BIT);
            bit_idx_d = '0;
            state_d   = DATA;
          end else begin
            timer_d = '0;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer - TIMER_W'(1);
        end
      end

      DATA: begin
        if (timer_done) begin
          shift_d[bit_idx] = rx_s;
          timer_d          = TIMER_W'(CLKS_PER_BIT);
          if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx + IDX_W'(1);
          end
        end else begin
          timer_d = timer - TIMER_W'(1);
        end
      end

      STOP: begin
        if (timer_done) begin
          timer_d = '0;
          if (rx_s == LINE_IDLE) begin
            d_d     = shift;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          timer_d = timer - TIMER_W'(1);
        end
      end

      // Line held low after a bad stop: do not re-arm until it idles high.
      WAIT_HIGH: begin
        if (rx_s == LINE_IDLE) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end

      default: begin
        timer_d   = '0;
        bit_idx_d = '0;
        state_d   = IDLE;
      end
    endcase

    busy_d = state_busy(state_d);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural serial transmitter queues the
// expected strobe per frame, a monitor pops and compares on every strobe.
module tb_uart_rx;

  localparam int unsigned CPB = 4;
  localparam int unsigned H   = CPB / 2;
  localparam int          LAT = 2 + int'(H) + 9 * int'(CPB) + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_i;
  logic [7:0] d_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx_i),
    .d_o         (d_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
    bit         b2b;
  } exp_t;

  exp_t       sb[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] model_d     = 8'h00;
  int         last_valid_cyc = -100000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hold the line at v for n bit-times; always called at a negedge.
  task automatic bit_time(input logic v, input int n);
    rx_i = v;
    repeat (n * int'(CPB)) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    bit_time(1'b1, n);
  endtask

  // One 8N1 frame; expected result computed from the frame's own stop level.
  task automatic send(input logic [7:0] b, input int stop_bits, input logic stop_lvl, input bit b2b);
    exp_t e;
    e.due = cyc + LAT;
    e.b2b = b2b;
    if (stop_lvl) begin
      e.is_err = 1'b0;
      e.data   = b;
      model_d  = b;
    end else begin
      e.is_err = 1'b1;
      e.data   = model_d;
    end
    sb.push_back(e);
    bit_time(1'b0, 1);
    for (int k = 0; k < 8; k++) begin
      bit_time(b[k], 1);
      if (k == 3) check("busy_mid_frame", 32'(busy_o), 32'd1);
    end
    bit_time(stop_lvl, stop_bits);
  endtask

  // Monitor: every strobe must match the oldest pending frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_o || frame_err_o) begin
        check("strobe_exclusive", 32'(valid_o & frame_err_o), 32'd0);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b d=0x%0h with no frame pending (cycle %0d)",
                   valid_o, frame_err_o, d_o, cyc);
        end else begin
          e = sb.pop_front();
          check("frame_err_o", 32'(frame_err_o), 32'(e.is_err));
          check("valid_o", 32'(valid_o), 32'(!e.is_err));
          check("d_o", 32'(d_o), 32'(e.data));
          vectors++;
          if (cyc < e.due - 1 || cyc > e.due + 1) begin
            miscompares++;
            $display("FAIL latency: strobe at cycle %0d expected %0d +/-1", cyc, e.due);
          end
          if (valid_o) begin
            if (e.b2b) check("b2b_gap", 32'(cyc - last_valid_cyc), 32'(10 * CPB));
            last_valid_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         gap;
    int         prev_gap;
    bit         seen;

    reset = 1'b1;
    rx_i  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_d_o", 32'(d_o), 32'h00);
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_frame_err_o", 32'(frame_err_o), 32'd0);
    check("reset_busy_o", 32'(busy_o), 32'd0);
    reset = 1'b0;
    idle_bits(2);

    // Single frame with latency check.
    send(8'hA5, 1, 1'b1, 1'b0);
    idle_bits(2);

    // Back-to-back frames, no idle gap.
    send(8'h00, 1, 1'b1, 1'b0);
    send(8'hFF, 1, 1'b1, 1'b1);
    idle_bits(2);

    // One-cycle glitch is rejected and busy drops quickly.
    rx_i = 1'b0;
    @(negedge clk);
    rx_i = 1'b1;
    seen = 1'b0;
    for (int n = 1; n < int'(H) + 3; n++) begin
      @(negedge clk);
      if (!busy_o) seen = 1'b1;
    end
    @(negedge clk);
    if (!busy_o) seen = 1'b1;
    check("glitch_busy_released", 32'(seen), 32'd1);
    idle_bits(2);
    send(8'h3C, 1, 1'b1, 1'b0);
    idle_bits(2);

    // Stop bit held low: frame error, then wait for line high.
    send(8'h3C, 3, 1'b0, 1'b0);
    check("busy_line_low", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (!busy_o) seen = 1'b1;
    end
    check("busy_after_line_high", 32'(seen), 32'd1);
    idle_bits(1);
    send(8'h5A, 1, 1'b1, 1'b0);
    idle_bits(2);

    // Reset part way through 0x96: frame abandoned, outputs cleared.
    bit_time(1'b0, 1);
    b = 8'h96;
    for (int k = 0; k < 4; k++) bit_time(b[k], 1);
    reset = 1'b1;
    rx_i  = 1'b1;
    @(negedge clk);
    check("midreset_d_o", 32'(d_o), 32'h00);
    check("midreset_valid_o", 32'(valid_o), 32'd0);
    check("midreset_frame_err_o", 32'(frame_err_o), 32'd0);
    check("midreset_busy_o", 32'(busy_o), 32'd0);
    reset   = 1'b0;
    model_d = 8'h00;
    idle_bits(12);
    send(8'h5A, 1, 1'b1, 1'b0);
    idle_bits(2);

    // Loopback of a deterministic byte, then random bytes with random gaps.
    send(8'h81, 1, 1'b1, 1'b0);
    prev_gap = 1;
    for (int i = 0; i < 256; i++) begin
      b   = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      send(b, 1, 1'b1, (prev_gap == 0));
      repeat (gap) @(negedge clk);
      prev_gap = gap;
    end

    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    idle_bits(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of uart_tx: 8N1, LSB first, idle-high line, same CLKS_PER_BIT bit timing.
- Synchronises the asynchronous serial input and qualifies the start bit at mid-bit.
- Samples 8 data bits and the stop bit at bit centres.
- Presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the host-side byte consumer; loops back directly against uart_tx.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range >= 4; H = CLKS_PER_BIT/2 (floor) is the half-bit offset.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
rx_i  input  1  asynchronous serial line, idle high.
d_o  output  8  last correctly framed byte; holds until the next good frame.
valid_o  output  1  one-cycle pulse: d_o updated this cycle.
frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
busy_o  output  1  high while a frame is in progress or the receiver waits for the line to return high.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset: the state machine goes to IDLE. Outputs reset to d_o=0x00, valid_o=0, frame_err_o=0, busy_o=0. Synchroniser flops reset to 1; bit counter, timer and shift register reset to 0.
- Reset mid-frame abandons the frame, produces no strobe and rearms in IDLE.
- Synchroniser: rx_s is rx_i delayed by 2 flops. All decisions use rx_s only.
- Timer: down-counter, loaded on every state entry and after every sample.
- Cycle T is the first IDLE cycle in which rx_s=0.
- IDLE: busy_o=0. When rx_s=0, load the timer with H and go to START.
- START: at cycle T+H, sample rx_s.
  - rx_s=1: false start; go to IDLE; no strobe.
  - rx_s=0: load the timer with CLKS_PER_BIT; go to DATA with bit_idx=0.
- DATA: data bit k (k=0..7) is sampled at cycle T+H+(k+1)*CLKS_PER_BIT. The sampled bit goes into shift[k] (LSB first). After k=7, go to STOP.
- STOP: sample at cycle T+H+9*CLKS_PER_BIT.
  - rx_s=1: in the next cycle d_o<=shift and valid_o=1 for exactly one cycle; go to IDLE.
  - rx_s=0: frame_err_o=1 for one cycle in the next cycle; d_o unchanged; go to WAIT_HIGH.
- WAIT_HIGH: busy_o=1. Stay until rx_s=1 (break/line-low protection), then go to IDLE. A start bit cannot be detected in this state.
- busy_o=1 in START, DATA, STOP and WAIT_HIGH; busy_o=0 in IDLE.
- valid_o and frame_err_o are never high in the same cycle.
- Back-to-back frames: after a good stop the receiver returns to IDLE at about mid-stop-bit. A start edge arriving one stop-bit after the previous frame is therefore detected, and no gap is required.
- Latency, rx_i start-bit fall to valid_o: 2 + H + 9*CLKS_PER_BIT + 1 cycles (±1 edge alignment). For CLKS_PER_BIT=4 this is 41 cycles.
- Glitches: a low pulse shorter than H cycles on rx_s is rejected as a false start.
- Unknown state encoding goes to IDLE.

Decomposition:
- uart_pkg holds:
  - state encodings IDLE, START, DATA, STOP, WAIT_HIGH;
  - DATA_BITS=8;
  - line level constants LINE_IDLE=1 and START_LVL=0.
- One sub-module: uart_rx_sync, a 2-flop synchroniser with reset value 1, parameterised by width (default 1) and reusable for other async inputs.
- The state machine, timer and shift register stay in uart_rx.

Test Plan:
1. CLKS_PER_BIT=4, drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) → one valid_o pulse with d_o=0xA5, at 41±1 cycles after the start edge; frame_err_o stays 0.
2. Back-to-back frames 0x00 then 0xFF, each with a single stop bit and no idle gap → two valid_o pulses, d_o=0x00 then 0xFF, exactly 10*CLKS_PER_BIT cycles apart.
3. rx_i low for 1 cycle, then high → no strobe; busy_o returns to 0 within H+3 cycles. A following 0x3C frame is received correctly.
4. Frame 0x3C with stop bit held low for 3 bit-times → frame_err_o pulses once; valid_o=0; d_o keeps its previous value; busy_o stays 1 until the line is high. A following 0x5A frame is received as 0x5A.
5. Assert reset for 1 cycle after 4 data bits of 0x96 → all outputs 0 the next cycle, no strobe for 0x96; a subsequent 0x5A frame gives d_o=0x5A with valid_o.
6. Loopback from uart_tx (same CLKS_PER_BIT): pulse e_i with d_i=0x81 → uart_rx delivers d_o=0x81 with valid_o and frame_err_o=0; repeat for 256 random bytes with zero mismatches.
